// File: rtl/data_table_ram.sv
// data_table_ram
//   Responder end of the data table interface. Single-port write and
//   fully pipelined read with a fixed RAM_LATENCY. After reset it can
//   sweep every entry to INIT_VALUE. Reads and writes are ignored until
//   that sweep has finished.
//
// Ports
//   clk_i         clock
//   rst_i         synchronous active-high reset
//   rd_addr_i     read address
//   rd_en_i       read request, one read per asserted cycle
//   rd_data_o     read data, holds its value between responses
//   rd_data_val_o one-cycle pulse per read response
//   wr_addr_i     write address
//   wr_data_i     write data
//   wr_en_i       write strobe
//   init_done_o   table usable (sweep finished)
module data_table_ram #(
  parameter int                 A_WIDTH       = 10,
  parameter int                 D_WIDTH       = 64,
  parameter int                 RAM_LATENCY   = 2,     // 1..4
  parameter bit                 RD_NEW_DATA   = 1'b1,
  parameter bit                 INIT_ON_RESET = 1'b1,
  parameter logic [D_WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [A_WIDTH-1:0] rd_addr_i,
  input  logic               rd_en_i,
  output logic [D_WIDTH-1:0] rd_data_o,
  output logic               rd_data_val_o,
  input  logic [A_WIDTH-1:0] wr_addr_i,
  input  logic [D_WIDTH-1:0] wr_data_i,
  input  logic               wr_en_i,
  output logic               init_done_o
);

  localparam int         DEPTH    = 2**A_WIDTH;
  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]         state;
  logic [A_WIDTH-1:0] init_cnt;
  logic               init_done;

  logic [D_WIDTH-1:0] mem [DEPTH];

  logic               ready;
  logic               rd_fire;
  logic               mem_we;
  logic [A_WIDTH-1:0] mem_waddr;
  logic [D_WIDTH-1:0] mem_wdata;
  logic               bypass;
  logic [D_WIDTH-1:0] rd_word;

  // Stage i holds a response that is i cycles old; the last stage is the output.
  logic [RAM_LATENCY:1]              vld_pipe;
  logic [RAM_LATENCY:1][D_WIDTH-1:0] data_pipe;

  assign ready   = (state == ST_READY);
  assign rd_fire = rd_en_i & ready;

  // The sweep owns the write port while in INIT; external writes are dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr_i;
    mem_wdata = wr_data_i;
    if (!rst_i) begin
      if (state == ST_INIT) begin
        mem_we    = 1'b1;
        mem_waddr = init_cnt;
        mem_wdata = INIT_VALUE;
      end else begin
        mem_we    = wr_en_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Same-address collision: mem still holds the old word at this edge,
  // so forwarding wr_data_i is what makes a read see the new data.
  assign bypass  = RD_NEW_DATA && wr_en_i && (wr_addr_i == rd_addr_i);
  assign rd_word = bypass ? wr_data_i : mem[rd_addr_i];

  // Control FSM and clearing sweep
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= INIT_ON_RESET ? ST_INIT : ST_READY;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == '1) begin
            state     <= ST_READY;
            init_done <= 1'b1;
          end
        end
        ST_READY: init_done <= 1'b1;
        default:  state     <= ST_READY;
      endcase
    end
  end

  // Read pipeline. Every stage only loads when the stage before it is
  // valid, so the output stage holds its word between responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe  <= '0;
      data_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_fire;
      if (rd_fire) data_pipe[1] <= rd_word;
      for (int i = 2; i <= RAM_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  assign rd_data_o     = data_pipe[RAM_LATENCY];
  assign rd_data_val_o = vld_pipe[RAM_LATENCY];
  assign init_done_o   = init_done;

endmodule

// File: tb/tb_data_table_ram.sv
module tb_data_table_ram;

  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int LAT = 2;
  localparam int DEP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;

  logic [DW-1:0] rd_data1, rd_data0;
  logic          val1, val0, done1, done0;

  always #5 clk = ~clk;

  // New-data and old-data collision variants, driven identically.
  data_table_ram #(.A_WIDTH(AW), .D_WIDTH(DW), .RAM_LATENCY(LAT),
                   .RD_NEW_DATA(1'b1), .INIT_ON_RESET(1'b1), .INIT_VALUE('0)) dut1 (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_en_i(rd_en),
    .rd_data_o(rd_data1), .rd_data_val_o(val1), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_en_i(wr_en), .init_done_o(done1));

  data_table_ram #(.A_WIDTH(AW), .D_WIDTH(DW), .RAM_LATENCY(LAT),
                   .RD_NEW_DATA(1'b0), .INIT_ON_RESET(1'b1), .INIT_VALUE('0)) dut0 (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_en_i(rd_en),
    .rd_data_o(rd_data0), .rd_data_val_o(val0), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_en_i(wr_en), .init_done_o(done0));

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } rsp_t;

  // Reference model: table contents, sweep progress, expected responses.
  logic [DW-1:0] m_mem [DEP];
  int            m_swept = 0;
  bit            m_ready = 0;
  bit            m_done  = 0;
  rsp_t          q1[$];
  rsp_t          q0[$];
  logic [DW-1:0] last1 = '0, last0 = '0;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic re, input int ra,
                       input logic we, input int wa, input int wd);
    rst = r; rd_en = re; rd_addr = AW'(ra);
    wr_en = we; wr_addr = AW'(wa); wr_data = DW'(wd);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 1'b0, 0, 0);
  endtask

  // One clock: update the model with the inputs sampled at this edge,
  // then check every output shortly after the edge.
  task automatic tick();
    rsp_t          r;
    logic [DW-1:0] oldw, neww;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q1.delete(); q0.delete();
      m_swept = 0; m_ready = 0; m_done = 0;
      last1 = '0; last0 = '0;
    end else if (!m_ready) begin
      m_mem[m_swept] = '0;
      m_swept++;
      if (m_swept == DEP) begin m_ready = 1; m_done = 1; end
    end else begin
      if (rd_en) begin
        oldw = m_mem[rd_addr];
        neww = (wr_en && wr_addr == rd_addr) ? wr_data : oldw;
        r.due = cyc + LAT - 1; r.d = neww; q1.push_back(r);
        r.d = oldw; q0.push_back(r);
      end
      if (wr_en) m_mem[wr_addr] = wr_data;
    end
    #1;
    if (q1.size() > 0 && q1[0].due == cyc) begin
      r = q1.pop_front();
      chk("val_new", 32'(val1), 32'd1);
      chk("data_new", 32'(rd_data1), 32'(r.d));
      last1 = r.d;
    end else begin
      chk("val_new", 32'(val1), 32'd0);
      chk("hold_new", 32'(rd_data1), 32'(last1));
    end
    if (q0.size() > 0 && q0[0].due == cyc) begin
      r = q0.pop_front();
      chk("val_old", 32'(val0), 32'd1);
      chk("data_old", 32'(rd_data0), 32'(r.d));
      last0 = r.d;
    end else begin
      chk("val_old", 32'(val0), 32'd0);
      chk("hold_old", 32'(rd_data0), 32'(last0));
    end
    chk("init_done_new", 32'(done1), 32'(m_done));
    chk("init_done_old", 32'(done0), 32'(m_done));
  endtask

  initial begin
    // Reset, then the sweep with a read and a write dropped in mid-way.
    drive(1'b1, 1'b0, 0, 1'b0, 0, 0);
    tick(); tick();
    for (int i = 0; i < DEP; i++) begin
      if (i == 3) drive(1'b0, 1'b1, 2, 1'b1, 2, 'h55);
      else        idle();
      tick();
    end

    // Whole table reads back as cleared.
    for (int a = 0; a < DEP; a++) begin
      drive(1'b0, 1'b1, a, 1'b0, 0, 0);
      tick();
    end
    idle(); tick(); tick();

    // Write then read on the next cycle.
    drive(1'b0, 1'b0, 0, 1'b1, 5, 'hAB); tick();
    drive(1'b0, 1'b1, 5, 1'b0, 0, 0);    tick();
    idle(); tick(); tick(); tick();

    // Same-cycle collision, then a plain read of the same word.
    drive(1'b0, 1'b0, 0, 1'b1, 3, 'h22); tick();
    drive(1'b0, 1'b1, 3, 1'b1, 3, 'h11); tick();
    drive(1'b0, 1'b1, 3, 1'b0, 0, 0);    tick();
    idle(); tick(); tick(); tick();

    // Back-to-back reads; addr 0 overwritten one cycle after its read.
    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 1'b0, 0, 1'b1, a, 'h10 + a);
      tick();
    end
    for (int a = 0; a < 8; a++) begin
      if (a == 1) drive(1'b0, 1'b1, a, 1'b1, 0, 'h99);
      else        drive(1'b0, 1'b1, a, 1'b0, 0, 0);
      tick();
    end
    idle(); tick(); tick(); tick();

    // Random traffic over a narrow address window to force collisions.
    for (int n = 0; n < 300; n++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 255)));
      tick();
    end
    idle(); tick(); tick(); tick();

    // Reset one cycle after a read, reset again mid-sweep, then full sweep.
    drive(1'b0, 1'b1, 5, 1'b0, 0, 0); tick();
    drive(1'b1, 1'b0, 0, 1'b0, 0, 0); tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, i, 1'b1, i, 'h77);
      tick();
    end
    drive(1'b1, 1'b0, 0, 1'b0, 0, 0); tick();
    for (int i = 0; i < DEP; i++) begin
      idle();
      tick();
    end
    drive(1'b0, 1'b1, 5, 1'b0, 0, 0); tick();
    drive(1'b0, 1'b1, 0, 1'b0, 0, 0); tick();
    idle(); tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
